logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pipe.sv | 97 +++++++++
 tb/tb_logic_unit_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit feeding a DEPTH-entry result FIFO; one-edge latency from accept to out_valid.
// Optional zero/parity flags per entry when LOGIC_UNIT_PIPE_FLAGS_EN is defined.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    output logic                     out_zero,
    output logic                     out_parity,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH;
`endif

    logic [WIDTH-1:0] op_res;
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    always_comb begin
        op_res = '0;
        case (op)
            3'b000: op_res = a & b;
            3'b001: op_res = a | b;
            3'b010: op_res = a ^ b;
            3'b011: op_res = ~(a | b);
            3'b100: op_res = a & ~b;
            3'b101: op_res = ~(a & b);
            3'b110: op_res = ~(a ^ b);
            default: op_res = a;
        endcase
    end

    // Entry layout: {parity, zero, result}; flags are computed once at push time.
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    assign entry = {^op_res, (op_res == '0), op_res};
`else
    assign entry = op_res;
`endif

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q] = entry;
        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Head is masked so nothing stale leaks out while empty or in reset.
    assign head   = mem_q[rptr_q];
    assign result = out_valid ? head[WIDTH-1:0] : '0;
    assign count  = count_q;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    assign out_zero   = out_valid & head[WIDTH];
    assign out_parity = out_valid & head[WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe (WIDTH=32, DEPTH=4); checks flags when LOGIC_UNIT_PIPE_FLAGS_EN is defined.
module tb_logic_unit_pipe;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [2:0]   op;
    logic [W-1:0] a, b, result;
    logic [2:0]   count;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    logic         out_zero, out_parity;
`endif

    int tot = 0;
    int bad = 0;
    logic [W-1:0] sb[$];

    logic_unit_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        .out_zero(out_zero), .out_parity(out_parity),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return x & ~y;
            3'd5: return ~(x & y);
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic chk_outs(input string tag);
        logic [W-1:0] hd;
        hd = (sb.size() != 0) ? sb[0] : '0;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(sb.size() < D));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
        chk({tag, ".count"},     64'(count),     64'(sb.size()));
        chk({tag, ".result"},    64'(result),    64'(hd));
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        chk({tag, ".zero"},   64'(out_zero),   64'((sb.size() != 0) && (hd == '0)));
        chk({tag, ".parity"}, 64'(out_parity), 64'((sb.size() != 0) && (^hd)));
`endif
    endtask

    // Called just after a falling edge; drives, checks pre-edge state, then advances one cycle.
    task automatic step(input string tag, input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] o, input logic [W-1:0] exp, input logic rdy);
        logic do_push, do_pop;
        in_valid  = v;
        a         = x;
        b         = y;
        op        = o;
        out_ready = rdy;
        #1;
        chk_outs(tag);
        do_push = v && (sb.size() < D);
        do_pop  = rdy && (sb.size() != 0);
        @(posedge clk);
        if (do_pop)  void'(sb.pop_front());
        if (do_push) sb.push_back(exp);
        @(negedge clk);
    endtask

    task automatic rnd(input string tag, input logic rdy);
        logic [W-1:0] x, y;
        logic [2:0]   o;
        x = $urandom;
        y = $urandom;
        o = 3'($urandom_range(0, 7));
        step(tag, 1'b1, x, y, o, model(x, y, o), rdy);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < D + 2 && sb.size() != 0; i++) step(tag, 1'b0, '0, '0, 3'd0, '0, 1'b1);
        chk({tag, ".empty"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #2;
        chk_outs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single AND, accepted on the first edge after reset release
        step("and", 1'b1, W'(1000000007), W'(143), 3'd0, W'(7), 1'b1);
        step("and_out", 1'b0, '0, '0, 3'd0, '0, 1'b1);
        step("and_idle", 1'b0, '0, '0, 3'd0, '0, 1'b1);

        // mixed ops returned in issue order
        step("mix0", 1'b1, W'(1000245), W'(134422), 3'd0, W'(131348), 1'b0);
        step("mix1", 1'b1, W'(1000245), W'(134422), 3'd1, W'(32'h000F4F37), 1'b0);
        step("mix7", 1'b1, W'(1000245), W'(134422), 3'd7, W'(1000245), 1'b0);
        drain("mix_drain");

        // every op once with random operands
        for (int o = 0; o < 8; o++) begin
            logic [W-1:0] x, y;
            x = $urandom; y = $urandom;
            step("ops", 1'b1, x, y, 3'(o), model(x, y, 3'(o)), 1'b1);
        end
        step("zero_res", 1'b1, W'(32'hF0F0_0000), W'(32'h0F0F_FFFF), 3'd0, '0, 1'b1);
        drain("ops_drain");

        // fill with 5, 5th must be dropped
        for (int i = 0; i < 5; i++) rnd("fill", 1'b0);
        chk("fill.count", 64'(count), 64'(D));
        // full: first edge only pops, next edge pushes and pops
        rnd("full_pop", 1'b1);
        rnd("pushpop", 1'b1);
        rnd("pushpop2", 1'b1);
        drain("fill_drain");

        // wrap: 10 continuous push/pop
        for (int i = 0; i < 10; i++) rnd("wrap", 1'b1);
        drain("wrap_drain");

        // reset mid-stream with 3 queued
        for (int i = 0; i < 3; i++) rnd("pre_rst", 1'b0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk_outs("mid_rst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        step("post_rst", 1'b1, W'(32'h1234_5678), W'(32'hFFFF_0000), 3'd2, W'(32'hEDCB_5678), 1'b0);
        step("post_rst_chk", 1'b0, '0, '0, 3'd0, '0, 1'b1);
        drain("post_drain");

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
